// File: rtl/pin_in_sync.sv
// Purpose: brings asynchronous pad inputs into clk_cog through a per-pin synchronizer chain,
//          with an optional per-pin deglitch filter and registered rise/fall pulses.
// Latency: SYNC_STAGES-1 edges unfiltered, SYNC_STAGES-1+FILTER_CYCLES edges filtered;
//          the pin_dir/pin_out bypass to sync_out is combinational.
// Backpressure: none; every pin is sampled on every clk_cog edge.
//
// Ports:
//   clk_cog  - sole clock
//   res      - synchronous active-high reset
//   pin_in   - raw pad inputs, asynchronous to clk_cog
//   pin_out  - core output data, returned directly on pins driven as outputs
//   pin_dir  - core direction, 1 = output
//   sync_out - conditioned input bus to the core
//   rise     - one-cycle pulse when a filtered bit goes 0->1
//   fall     - one-cycle pulse when a filtered bit goes 1->0
module pin_in_sync #(
    parameter int               WIDTH         = 32,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk_cog,
    input  logic             res,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] pin_out,
    input  logic [WIDTH-1:0] pin_dir,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Synchronizer chain: plain flop-to-flop, no logic between stages.
    logic [WIDTH-1:0] s [SYNC_STAGES];
    logic [WIDTH-1:0] smp;

    always_ff @(posedge clk_cog) begin
        if (res) begin
            for (int n = 0; n < SYNC_STAGES; n++) begin
                s[n] <= INIT;
            end
        end else begin
            s[0] <= pin_in;
            for (int n = 1; n < SYNC_STAGES; n++) begin
                s[n] <= s[n-1];
            end
        end
    end

    assign smp = s[SYNC_STAGES-1];

    // flt is the conditioned level; flt_nxt is the value it holds after the coming edge.
    logic [WIDTH-1:0] flt;
    logic [WIDTH-1:0] flt_nxt;

    generate
        if (FILTER_CYCLES > 0) begin : g_filt
            localparam int              CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] flt_q;

            // A pin only changes once it has disagreed with flt for FILTER_CYCLES samples in a row.
            always_comb begin
                flt_nxt = flt_q;
                for (int i = 0; i < WIDTH; i++) begin
                    if ((smp[i] != flt_q[i]) && (cnt[i] == CNT_LAST)) begin
                        flt_nxt[i] = smp[i];
                    end
                end
            end

            always_ff @(posedge clk_cog) begin
                if (res) begin
                    flt_q <= INIT;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    flt_q <= flt_nxt;
                    for (int i = 0; i < WIDTH; i++) begin
                        // Any agreeing sample, or the final disagreeing one, restarts the run,
                        // so the counter never wraps.
                        if ((smp[i] == flt_q[i]) || (cnt[i] == CNT_LAST)) begin
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end

            assign flt = flt_q;
        end else begin : g_nofilt
            // Unfiltered: flt is the last sync stage, which itself is the one-cycle-delayed
            // copy (reset to INIT) of the stage before it. Comparing the two lets the
            // registered edge flags line up with the cycle the new level appears.
            assign flt     = smp;
            assign flt_nxt = s[SYNC_STAGES-2];
        end
    endgenerate

    // Edge flags are registered alongside the level so they pulse in the same cycle.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= flt_nxt & ~flt;
            fall <= ~flt_nxt & flt;
        end
    end

    // Output pins see their own drive; the filter keeps tracking the pad regardless.
    assign sync_out = (pin_dir & pin_out) | (~pin_dir & flt);

endmodule

// File: tb/tb_pin_in_sync.sv
// Purpose: self-checking bench for pin_in_sync with a filtered (F=3) and an unfiltered (F=0) instance.
// Latency: checks are taken 1 time unit after each rising edge of clk_cog.
// Backpressure: none.
module tb_pin_in_sync;

    localparam int SS = 2;
    localparam int F  = 3;

    logic        clk_cog = 1'b0;
    logic        res;
    logic [31:0] pin_in, pin_out, pin_dir;
    logic [31:0] sync_f, rise_f, fall_f;
    logic [31:0] sync_u, rise_u, fall_u;

    always #5 clk_cog = ~clk_cog;

    pin_in_sync #(.WIDTH(32), .SYNC_STAGES(SS), .FILTER_CYCLES(F), .INIT(32'h0)) dut_f (
        .clk_cog(clk_cog), .res(res), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
        .sync_out(sync_f), .rise(rise_f), .fall(fall_f)
    );

    pin_in_sync #(.WIDTH(32), .SYNC_STAGES(SS), .FILTER_CYCLES(0), .INIT(32'h0)) dut_u (
        .clk_cog(clk_cog), .res(res), .pin_in(pin_in), .pin_out(pin_out), .pin_dir(pin_dir),
        .sync_out(sync_u), .rise(rise_u), .fall(fall_u)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a delay line of raw samples and the last F synchronized samples.
    // The filtered level follows the window only when all F samples agree.
    logic [31:0] dq[$];
    logic [31:0] hist[$];
    logic [31:0] flt3, mr3, mf3;
    logic [31:0] flt0, mr0, mf0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic [31:0] pi);
        logic [31:0] used, a, o, nf;
        if (r) begin
            dq.delete();
            for (int i = 0; i < SS; i++) dq.push_back(32'h0);
            hist.delete();
            flt3 = 32'h0; mr3 = 32'h0; mf3 = 32'h0;
            flt0 = 32'h0; mr0 = 32'h0; mf0 = 32'h0;
        end else begin
            used = dq[SS-1];
            dq.push_front(pi);
            void'(dq.pop_back());
            hist.push_back(used);
            if (hist.size() > F) void'(hist.pop_front());
            nf = flt3;
            if (hist.size() == F) begin
                a = 32'hFFFF_FFFF;
                o = 32'h0;
                foreach (hist[j]) begin
                    a &= hist[j];
                    o |= hist[j];
                end
                nf = a | (flt3 & o);
            end
            mr3 = nf & ~flt3;
            mf3 = ~nf & flt3;
            flt3 = nf;
            nf = dq[SS-1];
            mr0 = nf & ~flt0;
            mf0 = ~nf & flt0;
            flt0 = nf;
        end
    endtask

    task automatic cyc(input logic r, input logic [31:0] pi, input logic [31:0] pd, input logic [31:0] po);
        res     = r;
        pin_in  = pi;
        pin_dir = pd;
        pin_out = po;
        @(posedge clk_cog);
        model_step(r, pi);
        #1;
        chk("model_f_sync", sync_f, (pd & po) | (~pd & flt3));
        chk("model_f_rise", rise_f, mr3);
        chk("model_f_fall", fall_f, mf3);
        chk("model_u_sync", sync_u, (pd & po) | (~pd & flt0));
        chk("model_u_rise", rise_u, mr0);
        chk("model_u_fall", fall_u, mf0);
    endtask

    typedef struct {
        logic        r;
        logic [31:0] pi, pd, po;
        logic [31:0] es, er, ef;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [31:0] pi, po;

        // Reset and first-transition vectors for the F=3 instance.
        tbl[0]  = '{1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        tbl[7]  = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[12] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        tbl[13] = '{1'b0, 32'h0, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 32'h0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].pi, tbl[i].pd, tbl[i].po);
            chk($sformatf("tbl_sync[%0d]", i), sync_f, tbl[i].es);
            chk($sformatf("tbl_rise[%0d]", i), rise_f, tbl[i].er);
            chk($sformatf("tbl_fall[%0d]", i), fall_f, tbl[i].ef);
        end
        repeat (6) cyc(1'b0, 32'h0, 32'h0, 32'h0);

        // Filtered latency on pin 0: visible and pulsing after edge k+4 only.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 32'h1, 32'h0, 32'h0);
            chk("lat_sync", sync_f, (i >= 4) ? 32'h1 : 32'h0);
            chk("lat_rise", rise_f, (i == 4) ? 32'h1 : 32'h0);
            chk("lat_fall", fall_f, 32'h0);
        end
        repeat (6) cyc(1'b0, 32'h0, 32'h0, 32'h0);

        // Two-sample glitch on pin 5 is rejected.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, (i < 2) ? 32'h20 : 32'h0, 32'h0, 32'h0);
            chk("glitch_sync", sync_f, 32'h0);
            chk("glitch_rise", rise_f, 32'h0);
        end
        // Counter restarted: a held level needs the full latency again.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 32'h20, 32'h0, 32'h0);
            chk("glitch_cnt_sync", sync_f, (i >= 4) ? 32'h20 : 32'h0);
        end
        repeat (6) cyc(1'b0, 32'h0, 32'h0, 32'h0);

        // Bypass on pin 7.
        for (int i = 0; i < 6; i++) begin
            po = (i % 2 == 1) ? 32'h80 : 32'h0;
            cyc(1'b0, 32'h0, 32'h80, po);
            chk("byp_sync", sync_f, po);
            pin_out = ~po & 32'h80;
            #1;
            chk("byp_comb", sync_f, ~po & 32'h80);
            chk("byp_rise", rise_f, 32'h0);
        end
        pin_dir = 32'h0;
        #1;
        chk("byp_release_f", sync_f, 32'h0);
        chk("byp_release_u", sync_u, 32'h0);

        // Unfiltered fall on pin 31.
        repeat (8) cyc(1'b0, 32'h8000_0000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 32'h0, 32'h0);
            chk("unf_sync", sync_u, (i >= 1) ? 32'h0 : 32'h8000_0000);
            chk("unf_fall", fall_u, (i == 1) ? 32'h8000_0000 : 32'h0);
        end
        repeat (8) cyc(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset in the middle of a filter count on pin 3.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h8, 32'h0, 32'h0);
            chk("rstmid_pre_sync", sync_f, 32'h0);
        end
        cyc(1'b1, 32'h8, 32'h0, 32'h0);
        chk("rstmid_sync", sync_f, 32'h0);
        chk("rstmid_rise", rise_f, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 32'h8, 32'h0, 32'h0);
            chk("rstmid_post_rise", rise_f, (i == 5) ? 32'h8 : 32'h0);
            chk("rstmid_post_sync", sync_f, (i >= 5) ? 32'h8 : 32'h0);
        end

        // Randomized traffic against the reference model.
        pi = 32'h8;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) pi = $urandom;
            else pi = pi ^ ($urandom & $urandom & $urandom);
            cyc($urandom_range(0, 49) == 0, pi, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
